// File: rtl/ramio_port_arbiter.sv
// Two-master arbiter/sequencer for RAMIO port A (m0 = CPU data side, m1 = DMA/debug loader).
// Latency: write ack 2 cycles after request sample, read ack 3 (+1 per mem_bsy cycle), null ack 1.
// Backpressure: mem_bsy stalls ISSUE; requesters hold req until ack; TIMEOUT bounds ISSUE+WAIT.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration (default: fixed m0 priority).
module ramio_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  // master 0
  input  logic        m0_req,
  input  logic [2:0]  m0_re,
  input  logic [1:0]  m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_din,
  output logic [31:0] m0_dout,
  output logic        m0_ack,
  output logic        m0_err,
  // master 1
  input  logic        m1_req,
  input  logic [2:0]  m1_re,
  input  logic [1:0]  m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_din,
  output logic [31:0] m1_dout,
  output logic        m1_ack,
  output logic        m1_err,
  // current owner, one-hot
  output logic [1:0]  gnt,
  // RAMIO port A
  output logic        mem_en,
  output logic [2:0]  mem_re,
  output logic [1:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  input  logic        mem_valid,
  input  logic        mem_bsy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // The counter is 8 bits wide because TIMEOUT is limited to 1..255.
  localparam logic [7:0] TO_L = TIMEOUT[7:0];

  state_t      state_q, state_d;
  logic        owner_q, owner_d;      // 0 = m0, 1 = m1
  logic [2:0]  re_q, re_d;
  logic [1:0]  we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] m0_dout_q, m0_dout_d;
  logic [31:0] m1_dout_q, m1_dout_d;

  logic        any_req;
  logic        pick_m1;
  logic [2:0]  sel_re;
  logic [1:0]  sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_din;
  logic [7:0]  cnt_inc;
  logic        to_hit;

  assign any_req = m0_req | m1_req;
  assign cnt_inc = cnt_q + 8'd1;
  // Timeout fires on the cycle whose increment brings the count up to TIMEOUT.
  assign to_hit  = (cnt_inc == TO_L);

`ifdef ARB_ROUND_ROBIN_EN
  // Pointer remembers the last granted master; 1 = m1, so m0 wins the first tie.
  logic last_q, last_d;

  // Winner selection: on a tie the master not granted last wins.
  always_comb begin
    pick_m1 = m1_req & (~m0_req | ~last_q);
  end

  // Round-robin pointer register, updated on every grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  // Pointer next state: follow the winner whenever a grant is issued from IDLE.
  always_comb begin
    last_d = last_q;
    if (state_q == S_IDLE && any_req) begin
      last_d = pick_m1;
    end
  end
`else
  // Winner selection: fixed priority, m1 only when m0 is not requesting.
  always_comb begin
    pick_m1 = ~m0_req;
  end
`endif

  // Mux the winner's command so IDLE can latch it in one step.
  always_comb begin
    sel_re   = m0_re;
    sel_we   = m0_we;
    sel_addr = m0_addr;
    sel_din  = m0_din;
    if (pick_m1) begin
      sel_re   = m1_re;
      sel_we   = m1_we;
      sel_addr = m1_addr;
      sel_din  = m1_din;
    end
  end

  // State and datapath registers; reset aborts any transaction without an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      re_q      <= 3'd0;
      we_q      <= 2'd0;
      addr_q    <= 32'd0;
      din_q     <= 32'd0;
      cnt_q     <= 8'd0;
      err_q     <= 1'b0;
      m0_dout_q <= 32'd0;
      m1_dout_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      re_q      <= re_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      m0_dout_q <= m0_dout_d;
      m1_dout_q <= m1_dout_d;
    end
  end

  // Next-state logic: grant, issue, wait for data, timeout, and the single ack cycle.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    re_d      = re_q;
    we_d      = we_q;
    addr_d    = addr_q;
    din_d     = din_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    m0_dout_d = m0_dout_q;
    m1_dout_d = m1_dout_q;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        err_d = 1'b0;
        if (any_req) begin
          owner_d = pick_m1;
          re_d    = sel_re;
          we_d    = sel_we;
          addr_d  = sel_addr;
          din_d   = sel_din;
          // A command with neither read nor write acks without touching memory.
          if (sel_we == 2'b00 && sel_re == 3'b000) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        cnt_d = cnt_inc;
        // A write accepted this cycle completes even if the budget runs out now.
        if (!mem_bsy && we_q != 2'b00) begin
          state_d = S_DONE;
        end else if (to_hit) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          if (owner_q) m1_dout_d = 32'd0;
          else         m0_dout_d = 32'd0;
        end else if (!mem_bsy) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        cnt_d = cnt_inc;
        // Data arriving on the last budgeted cycle still counts as success.
        if (mem_valid) begin
          state_d = S_DONE;
          if (owner_q) m1_dout_d = mem_dout;
          else         m0_dout_d = mem_dout;
        end else if (to_hit) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          if (owner_q) m1_dout_d = 32'd0;
          else         m0_dout_d = 32'd0;
        end
      end

      S_DONE: begin
        // Requests are deliberately ignored here so the owner can drop req after ack.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Memory-side and grant outputs are pure decodes of the registered state.
  always_comb begin
    gnt      = 2'b00;
    mem_en   = 1'b0;
    mem_re   = 3'd0;
    mem_we   = 2'd0;
    mem_addr = 32'd0;
    mem_din  = 32'd0;
    unique case (state_q)
      S_ISSUE: begin
        gnt      = owner_q ? 2'b10 : 2'b01;
        mem_en   = 1'b1;
        mem_re   = re_q;
        mem_we   = we_q;
        mem_addr = addr_q;
        mem_din  = din_q;
      end
      S_WAIT: begin
        gnt      = owner_q ? 2'b10 : 2'b01;
        mem_en   = 1'b1;
        mem_re   = re_q;
        mem_addr = addr_q;
        mem_din  = din_q;
      end
      S_DONE: begin
        gnt = owner_q ? 2'b10 : 2'b01;
      end
      default: begin
        gnt = 2'b00;
      end
    endcase
  end

  // Ack pulses for the owner only; err is meaningful only alongside ack.
  always_comb begin
    m0_ack = (state_q == S_DONE) && !owner_q;
    m1_ack = (state_q == S_DONE) &&  owner_q;
    m0_err = m0_ack && err_q;
    m1_err = m1_ack && err_q;
  end

  assign m0_dout = m0_dout_q;
  assign m1_dout = m1_dout_q;

endmodule
